// File: rtl/atm_core_multi.sv
// atm_core_multi: multi-account ATM core covering card insertion, PIN check, withdraw/deposit and mini-statement.
// Define ATM_HIST_EN to build per-account transaction history and the STMT streaming state.
module atm_core_multi #(
   parameter int unsigned NUM_ACCOUNTS = 4,
   parameter int unsigned ID_W = $clog2(NUM_ACCOUNTS),
   parameter int unsigned PIN_DIGITS = 4,
   parameter logic [4*PIN_DIGITS-1:0] DEFAULT_PIN = 16'h0123,
   parameter int unsigned BAL_W = 16,
   parameter int unsigned AMT_W = 8,
   parameter int unsigned INIT_BAL = 1000,
   parameter int unsigned MAX_TRIES = 3,
   parameter int unsigned HIST_DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             card_present,
   input  logic [ID_W-1:0]  card_id,
   input  logic             key_valid,
   input  logic [3:0]       key,
   input  logic             txn_valid,
   input  logic [1:0]       txn_type,
   input  logic [AMT_W-1:0] txn_amount,
   output logic [2:0]       status,
   output logic [BAL_W-1:0] balance,
   output logic             locked,
   output logic             stmt_valid,
   output logic [AMT_W:0]   stmt_data,
   output logic             stmt_last
);

   localparam int unsigned PIN_W  = 4 * PIN_DIGITS;
   localparam int unsigned DIG_W  = (PIN_DIGITS > 1) ? $clog2(PIN_DIGITS) : 1;
   localparam int unsigned FAIL_W = $clog2(MAX_TRIES + 1);
   localparam logic [DIG_W-1:0]  DIG_LAST = DIG_W'(PIN_DIGITS - 1);
   localparam logic [FAIL_W-1:0] FAIL_MAX = FAIL_W'(MAX_TRIES);

`ifdef ATM_HIST_EN
   localparam int unsigned PTR_W = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(HIST_DEPTH + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(HIST_DEPTH);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(HIST_DEPTH - 1);

   typedef enum logic [2:0] {S_IDLE, S_PIN, S_MENU, S_STMT, S_HOLD} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_PIN, S_MENU, S_HOLD} state_t;
`endif

   typedef enum logic [2:0] {
      ST_IDLE, ST_PIN, ST_MENU, ST_DONE, ST_NSF, ST_BADPIN, ST_LOCKED, ST_REJECT
   } status_t;

   state_t             state_q, state_n;
   status_t            status_q, status_n;
   logic [BAL_W-1:0]   balance_q, balance_n;
   logic               locked_q, locked_n;
   logic               card_q;
   logic [ID_W-1:0]    id_q, id_n;
   logic [PIN_W-1:0]   pin_q, pin_n;
   logic [DIG_W-1:0]   dig_q, dig_n;

   logic [BAL_W-1:0]   bal_mem [NUM_ACCOUNTS];
   logic [FAIL_W-1:0]  fail_mem [NUM_ACCOUNTS];
   logic               lock_mem [NUM_ACCOUNTS];

   logic               bal_we, fail_we, lock_we;
   logic [BAL_W-1:0]   bal_wd;
   logic [FAIL_W-1:0]  fail_wd;

   logic [BAL_W-1:0]   cur_bal, amt_ext;
   logic [BAL_W:0]     sum;
   logic [FAIL_W-1:0]  fail_inc;
   logic [PIN_W-1:0]   pin_shift;

   assign cur_bal   = bal_mem[id_q];
   assign amt_ext   = BAL_W'(txn_amount);
   assign sum       = {1'b0, cur_bal} + {1'b0, amt_ext};
   assign fail_inc  = fail_mem[id_q] + 1'b1;
   assign pin_shift = (pin_q << 4) | PIN_W'(key);

`ifdef ATM_HIST_EN
   logic [AMT_W:0]     hist_mem [NUM_ACCOUNTS][HIST_DEPTH];
   logic [PTR_W-1:0]   hist_ptr [NUM_ACCOUNTS];
   logic [CNT_W-1:0]   hist_cnt [NUM_ACCOUNTS];
   logic               hist_we;
   logic [AMT_W:0]     hist_wd;
   logic [CNT_W-1:0]   stmt_idx_q, stmt_idx_n;
   logic               stmt_valid_q, stmt_valid_n, stmt_last_q, stmt_last_n;
   logic [AMT_W:0]     stmt_data_q, stmt_data_n;
   logic [PTR_W-1:0]   cur_ptr;
   logic [CNT_W-1:0]   cur_cnt;

   assign cur_ptr = hist_ptr[id_q];
   assign cur_cnt = hist_cnt[id_q];

   // Slot holding the entry `age` writes back from the newest (age 0 = newest).
   function automatic logic [PTR_W-1:0] hist_pos(input logic [PTR_W-1:0] ptr,
                                                 input logic [CNT_W-1:0] age);
      int unsigned p;
      p = (32'(ptr) + HIST_DEPTH - 1 - 32'(age)) % HIST_DEPTH;
      return PTR_W'(p);
   endfunction

   assign stmt_valid = stmt_valid_q;
   assign stmt_data  = stmt_data_q;
   assign stmt_last  = stmt_last_q;
`else
   assign stmt_valid = 1'b0;
   assign stmt_data  = '0;
   assign stmt_last  = 1'b0;
`endif

   assign status  = status_q;
   assign balance = balance_q;
   assign locked  = locked_q;

   always_comb begin
      state_n   = state_q;
      status_n  = status_q;
      balance_n = balance_q;
      locked_n  = locked_q;
      id_n      = id_q;
      pin_n     = pin_q;
      dig_n     = dig_q;
      bal_we    = 1'b0;
      bal_wd    = cur_bal;
      fail_we   = 1'b0;
      fail_wd   = '0;
      lock_we   = 1'b0;
`ifdef ATM_HIST_EN
      hist_we      = 1'b0;
      hist_wd      = '0;
      stmt_idx_n   = stmt_idx_q;
      stmt_valid_n = 1'b0;
      stmt_data_n  = '0;
      stmt_last_n  = 1'b0;
`endif
      // Card removal aborts any session and drops a coincident strobe.
      if (state_q != S_IDLE && !card_present) begin
         state_n   = S_IDLE;
         status_n  = ST_IDLE;
         balance_n = '0;
         locked_n  = 1'b0;
         pin_n     = '0;
         dig_n     = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (card_present && !card_q) begin
                  id_n      = card_id;
                  pin_n     = '0;
                  dig_n     = '0;
                  balance_n = '0;
                  if (lock_mem[card_id]) begin
                     state_n  = S_HOLD;
                     status_n = ST_LOCKED;
                     locked_n = 1'b1;
                  end else begin
                     state_n  = S_PIN;
                     status_n = ST_PIN;
                     locked_n = 1'b0;
                  end
               end
            end
            S_PIN: begin
               if (key_valid && key == 4'hC) begin
                  state_n  = S_HOLD;
                  status_n = ST_IDLE;
               end else if (key_valid && key <= 4'd9) begin
                  if (dig_q == DIG_LAST) begin
                     pin_n   = '0;
                     dig_n   = '0;
                     fail_we = 1'b1;
                     if (pin_shift == DEFAULT_PIN) begin
                        fail_wd   = '0;
                        state_n   = S_MENU;
                        status_n  = ST_MENU;
                        balance_n = cur_bal;
                     end else begin
                        fail_wd = fail_inc;
                        if (fail_inc >= FAIL_MAX) begin
                           lock_we  = 1'b1;
                           state_n  = S_HOLD;
                           status_n = ST_LOCKED;
                           locked_n = 1'b1;
                        end else begin
                           status_n = ST_BADPIN;
                        end
                     end
                  end else begin
                     pin_n = pin_shift;
                     dig_n = dig_q + 1'b1;
                  end
               end
            end
            S_MENU: begin
               if (txn_valid) begin
                  balance_n = cur_bal;
                  case (txn_type)
                     2'd0: begin
                        if (txn_amount == '0)      status_n = ST_REJECT;
                        else if (amt_ext > cur_bal) status_n = ST_NSF;
                        else begin
                           bal_we    = 1'b1;
                           bal_wd    = cur_bal - amt_ext;
                           balance_n = cur_bal - amt_ext;
                           status_n  = ST_DONE;
`ifdef ATM_HIST_EN
                           hist_we = 1'b1;
                           hist_wd = {1'b0, txn_amount};
`endif
                        end
                     end
                     2'd1: begin
                        if (txn_amount == '0 || sum[BAL_W]) status_n = ST_REJECT;
                        else begin
                           bal_we    = 1'b1;
                           bal_wd    = sum[BAL_W-1:0];
                           balance_n = sum[BAL_W-1:0];
                           status_n  = ST_DONE;
`ifdef ATM_HIST_EN
                           hist_we = 1'b1;
                           hist_wd = {1'b1, txn_amount};
`endif
                        end
                     end
                     2'd2: begin
`ifdef ATM_HIST_EN
                        status_n = ST_DONE;
                        if (cur_cnt == '0) begin
                           stmt_last_n = 1'b1;
                        end else begin
                           stmt_valid_n = 1'b1;
                           stmt_data_n  = hist_mem[id_q][hist_pos(cur_ptr, '0)];
                           if (cur_cnt == CNT_W'(1)) begin
                              stmt_last_n = 1'b1;
                           end else begin
                              state_n    = S_STMT;
                              stmt_idx_n = CNT_W'(1);
                           end
                        end
`else
                        status_n = ST_REJECT;
`endif
                     end
                     default: begin
                        state_n   = S_HOLD;
                        status_n  = ST_IDLE;
                        balance_n = '0;
                     end
                  endcase
               end
            end
`ifdef ATM_HIST_EN
            S_STMT: begin
               stmt_valid_n = 1'b1;
               stmt_data_n  = hist_mem[id_q][hist_pos(cur_ptr, stmt_idx_q)];
               stmt_idx_n   = stmt_idx_q + 1'b1;
               if (stmt_idx_q == cur_cnt - 1'b1) begin
                  stmt_last_n = 1'b1;
                  state_n     = S_MENU;
               end
            end
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         status_q  <= ST_IDLE;
         balance_q <= '0;
         locked_q  <= 1'b0;
         card_q    <= 1'b0;
         id_q      <= '0;
         pin_q     <= '0;
         dig_q     <= '0;
      end else begin
         state_q   <= state_n;
         status_q  <= status_n;
         balance_q <= balance_n;
         locked_q  <= locked_n;
         card_q    <= card_present;
         id_q      <= id_n;
         pin_q     <= pin_n;
         dig_q     <= dig_n;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned a = 0; a < NUM_ACCOUNTS; a++) begin
            bal_mem[a]  <= BAL_W'(INIT_BAL);
            fail_mem[a] <= '0;
            lock_mem[a] <= 1'b0;
         end
      end else begin
         if (bal_we)  bal_mem[id_q]  <= bal_wd;
         if (fail_we) fail_mem[id_q] <= fail_wd;
         if (lock_we) lock_mem[id_q] <= 1'b1;
      end
   end

`ifdef ATM_HIST_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stmt_idx_q   <= '0;
         stmt_valid_q <= 1'b0;
         stmt_data_q  <= '0;
         stmt_last_q  <= 1'b0;
         for (int unsigned a = 0; a < NUM_ACCOUNTS; a++) begin
            hist_ptr[a] <= '0;
            hist_cnt[a] <= '0;
            for (int unsigned j = 0; j < HIST_DEPTH; j++) hist_mem[a][j] <= '0;
         end
      end else begin
         stmt_idx_q   <= stmt_idx_n;
         stmt_valid_q <= stmt_valid_n;
         stmt_data_q  <= stmt_data_n;
         stmt_last_q  <= stmt_last_n;
         if (hist_we) begin
            hist_mem[id_q][cur_ptr] <= hist_wd;
            hist_ptr[id_q] <= (cur_ptr == PTR_LAST) ? '0 : cur_ptr + 1'b1;
            if (cur_cnt != CNT_FULL) hist_cnt[id_q] <= cur_cnt + 1'b1;
         end
      end
   end
`endif

endmodule
